cu_data_write_pack: RTL

Packs a stream of 32-bit result words from a compute unit into 128-byte cachelines and presents each line as two 64-byte halves (`write_data_0_out`, `write_data_1_out`). The outputs feed the write-data input FIFOs of the data write engine. For each line the block generates the `CommandTagLine` fields the engine needs: byte address offset, valid word count, struct tag and CU id. A final partial line is zero-padded and flushed at end of job.

---
 rtl/cu_data_write_pack.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cu_data_write_pack.sv
// Compute-unit result packer: gathers 32-bit words into 128-byte cachelines and
// hands each line to the data write engine as two 64-byte halves with command tags.
package cu_data_write_pack_pkg;

  localparam int ARRAY_SIZE_BITS = 32;
  localparam int CU_ID_BITS      = 8;
  localparam int HALF_LINE_BITS  = 512;

  localparam logic [CU_ID_BITS-1:0] DATA_WRITE_CONTROL_ID = 8'h21;

  typedef enum logic [2:0] {
    STRUCT_INVALID = 3'd0,
    READ_DATA      = 3'd1,
    WRITE_DATA     = 3'd2,
    READ_GRAPH     = 3'd3
  } array_struct_t;

  typedef enum logic [1:0] {
    CMD_INVALID = 2'd0,
    CMD_READ    = 2'd1,
    CMD_WRITE   = 2'd2
  } cmd_type_t;

  typedef enum logic [1:0] {
    ABT_NONE = 2'd0,
    STRICT   = 2'd1,
    ABORT    = 2'd2,
    PREF     = 2'd3
  } abt_t;

  typedef struct packed {
    array_struct_t                array_struct;
    cmd_type_t                    cmd_type;
    logic [CU_ID_BITS-1:0]        cu_id;
    abt_t                         abt;
    logic [6:0]                   cacheline_offest;
    logic [ARRAY_SIZE_BITS-1:0]   address_offest;
    logic [5:0]                   real_size;
  } CommandTagLine;

  typedef struct packed {
    logic                         valid;
    CommandTagLine                cmd;
    logic [0:HALF_LINE_BITS-1]    data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic empty;
    logic full;
    logic alfull;
  } BufferStatus;

endpackage

module cu_data_write_pack
  import cu_data_write_pack_pkg::*;
#(
  parameter logic [CU_ID_BITS-1:0] CU_ID          = DATA_WRITE_CONTROL_ID,
  parameter int                    WORDS_PER_LINE = 32
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       enabled_in,
  input  logic                       job_start,
  input  logic [ARRAY_SIZE_BITS-1:0] job_size,
  input  logic                       word_in_valid,
  input  logic [31:0]                word_in_data,
  output logic                       word_in_ready,
  input  BufferStatus                write_data_in_buffer_status,
  output ReadWriteDataLine           write_data_0_out,
  output ReadWriteDataLine           write_data_1_out,
  output logic [ARRAY_SIZE_BITS-1:0] job_words_packed,
  output logic                       job_done
);

  localparam int HALF_WORDS = WORDS_PER_LINE / 2;
  localparam int CNT_W      = $clog2(WORDS_PER_LINE + 1);
  localparam int IDX_W      = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

  state_t                             state_q;
  logic                               enabled_q;
  logic [ARRAY_SIZE_BITS-1:0]         job_size_q;
  logic [ARRAY_SIZE_BITS-1:0]         words_q;
  logic [CNT_W-1:0]                   word_cnt_q;
  logic [ARRAY_SIZE_BITS-1:0]         line_idx_q;
  logic [WORDS_PER_LINE-1:0][31:0]    line_q;
  ReadWriteDataLine                   out0_q;
  ReadWriteDataLine                   out1_q;

  logic                               accept;
  logic                               line_full;
  logic                               alfull;
  logic [ARRAY_SIZE_BITS-1:0]         words_d;
  CommandTagLine                      cmd_d;
  logic [0:HALF_LINE_BITS-1]          data0_d;
  logic [0:HALF_LINE_BITS-1]          data1_d;
  logic                               unused_status;

  assign word_in_ready    = (state_q == FILL) && enabled_q;
  assign accept           = word_in_ready && word_in_valid;
  assign words_d          = words_q + ARRAY_SIZE_BITS'(1);
  assign line_full        = (word_cnt_q == CNT_W'(WORDS_PER_LINE - 1));
  assign alfull           = write_data_in_buffer_status.alfull;
  assign unused_status    = ^{write_data_in_buffer_status.empty, write_data_in_buffer_status.full};

  assign write_data_0_out = out0_q;
  assign write_data_1_out = out1_q;
  assign job_words_packed = words_q;
  assign job_done         = (state_q == DONE);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    cmd_d                  = '0;
    cmd_d.array_struct     = WRITE_DATA;
    cmd_d.cmd_type         = CMD_WRITE;
    cmd_d.cu_id            = CU_ID;
    cmd_d.abt              = STRICT;
    cmd_d.cacheline_offest = '0;
    cmd_d.address_offest   = line_idx_q << 7;
    cmd_d.real_size        = word_cnt_q;
  end

  // Slot j lands at [j*32 +: 32] of an ascending vector, so word 0 sits in the MSBs.
  always_comb begin
    data0_d = '0;
    data1_d = '0;
    for (int j = 0; j < HALF_WORDS; j++) begin
      data0_d[j*32 +: 32] = line_q[j];
      data1_d[j*32 +: 32] = line_q[j + HALF_WORDS];
    end
  end

  // NOTE: the line buffer is reset on purpose: a zero-padded partial line must never
  // expose words from an earlier job or from before a mid-job reset.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      enabled_q  <= 1'b0;
      job_size_q <= '0;
      words_q    <= '0;
      word_cnt_q <= '0;
      line_idx_q <= '0;
      line_q     <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
    end else begin
      enabled_q <= enabled_in;
      out0_q    <= '0;
      out1_q    <= '0;
      if (enabled_q) begin
        unique case (state_q)
          IDLE, DONE: begin
            if (job_start) begin
              job_size_q <= job_size;
              words_q    <= '0;
              word_cnt_q <= '0;
              line_idx_q <= '0;
              line_q     <= '0;
              state_q    <= (job_size == '0) ? DONE : FILL;
            end
          end
          FILL: begin
            if (accept) begin
              line_q[word_cnt_q[IDX_W-1:0]] <= word_in_data;
              word_cnt_q <= word_cnt_q + CNT_W'(1);
              words_q    <= words_d;
              if (line_full || (words_d == job_size_q)) state_q <= EMIT;
            end
          end
          EMIT: begin
            // Half 1 is always marked valid so both engine FIFOs advance together.
            if (!alfull) begin
              out0_q     <= '{valid: 1'b1, cmd: cmd_d, data: data0_d};
              out1_q     <= '{valid: 1'b1, cmd: cmd_d, data: data1_d};
              line_q     <= '0;
              word_cnt_q <= '0;
              if (words_q == job_size_q) begin
                state_q <= DONE;
              end else begin
                state_q    <= FILL;
                line_idx_q <= line_idx_q + ARRAY_SIZE_BITS'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule
